// File: rtl/sata_pkg.sv
// Shared definitions for the SATA Tx framer: primitives, CRC seed/polynomial,
// framer state encoding and the dword-wise CRC step.
package sata_pkg;

  localparam logic [31:0] PRIM_SYNC = 32'hB5B5957C;
  localparam logic [31:0] PRIM_SOF  = 32'h3737B57C;
  localparam logic [31:0] PRIM_EOF  = 32'hD5D5B57C;
  localparam logic [31:0] PRIM_HOLD = 32'hD5D5AA7C;

  localparam logic [31:0] CRC_SEED = 32'h52325032;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

  localparam int unsigned MAX_DW_DEFAULT = 2048;

  typedef logic [11:0] dw_cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_CRC,
    ST_EOF,
    ST_DROP
  } tx_state_e;

  // MSB-first CRC-32 over one dword, no reflection and no final inversion.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 32; i++) begin
      c = c[31] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/sata_tx_framer_crc.sv
// Running SATA frame CRC: reloads the seed on crc_rst, folds in one dword per
// data_valid cycle.
module crc
  import sata_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        crc_rst,
  input  logic        data_valid,
  input  logic [31:0] data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (crc_rst) begin
      crc_d = CRC_SEED;
    end else if (data_valid) begin
      crc_d = crc32_step(crc_q, data_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= CRC_SEED;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sata_tx_framer.sv
// SATA Tx framer: wraps transport-layer FIS dwords in SOF/CRC/EOF primitives.
// Defining SATA_TX_CRC_ERR_INJ_EN adds input crc_err_inj (flips CRC bit 0).
module sata_tx_framer
  import sata_pkg::*;
#(
  parameter int unsigned MAX_DW = MAX_DW_DEFAULT
) (
  input  logic        clk_75m,
  input  logic        rst_n,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  output logic        tx_isk,
  output logic        frame_done,
  output logic        err_oversize
`ifdef SATA_TX_CRC_ERR_INJ_EN
  ,
  input  logic        crc_err_inj
`endif
);

  localparam dw_cnt_t LAST_IDX = dw_cnt_t'(MAX_DW - 1);

  tx_state_e   state_q, state_d;
  logic [31:0] tx_data_q, tx_data_d;
  logic        tx_isk_q, tx_isk_d;
  logic        frame_done_q, frame_done_d;
  logic        err_ovf_q, err_ovf_d;
  logic        ovf_q, ovf_d;
  dw_cnt_t     cnt_q, cnt_d;

  logic        accept;
  logic        last_slot;
  logic        crc_rst;
  logic        crc_upd;
  logic [31:0] crc_val;
  logic [31:0] crc_word;

`ifdef SATA_TX_CRC_ERR_INJ_EN
  logic inj_q, inj_d;
  assign crc_word = crc_val ^ {31'b0, inj_q};
`else
  assign crc_word = crc_val;
`endif

  assign accept    = s_valid && s_ready;
  assign last_slot = (cnt_q == LAST_IDX);
  assign crc_rst   = (state_q == ST_IDLE) || (state_q == ST_SOF);
  assign crc_upd   = (state_q == ST_DATA) && accept;

  crc u_crc (
    .clk_i      (clk_75m),
    .rst_ni     (rst_n),
    .crc_rst    (crc_rst),
    .data_valid (crc_upd),
    .data_i     (s_data),
    .crc_o      (crc_val)
  );

  always_ff @(posedge clk_75m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tx_ready) begin
      unique case (state_q)
        ST_IDLE: if (s_valid) state_d = ST_SOF;
        ST_SOF:  state_d = ST_DATA;
        // The MAX_DW-th dword closes the frame even without s_last.
        ST_DATA: if (accept && (s_last || last_slot)) state_d = ST_CRC;
        ST_CRC:  state_d = ST_EOF;
        ST_EOF:  state_d = ovf_q ? ST_DROP : ST_IDLE;
        ST_DROP: if (accept && s_last) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready      = tx_ready && ((state_q == ST_DATA) || (state_q == ST_DROP));
    tx_data_d    = tx_data_q;
    tx_isk_d     = tx_isk_q;
    frame_done_d = 1'b0;
    err_ovf_d    = 1'b0;
    ovf_d        = ovf_q;
    cnt_d        = cnt_q;
`ifdef SATA_TX_CRC_ERR_INJ_EN
    inj_d        = inj_q;
`endif
    if (tx_ready) begin
      unique case (state_q)
        ST_IDLE: begin
          tx_data_d = PRIM_SYNC;
          tx_isk_d  = 1'b1;
        end
        ST_SOF: begin
          tx_data_d = PRIM_SOF;
          tx_isk_d  = 1'b1;
          cnt_d     = '0;
          ovf_d     = 1'b0;
`ifdef SATA_TX_CRC_ERR_INJ_EN
          inj_d     = crc_err_inj;
`endif
        end
        ST_DATA: begin
          if (accept) begin
            tx_data_d = s_data;
            tx_isk_d  = 1'b0;
            cnt_d     = cnt_q + dw_cnt_t'(1);
            if (!s_last && last_slot) begin
              err_ovf_d = 1'b1;
              ovf_d     = 1'b1;
            end
          end else begin
            tx_data_d = PRIM_HOLD;
            tx_isk_d  = 1'b1;
          end
        end
        ST_CRC: begin
          tx_data_d = crc_word;
          tx_isk_d  = 1'b0;
        end
        ST_EOF: begin
          tx_data_d    = PRIM_EOF;
          tx_isk_d     = 1'b1;
          frame_done_d = 1'b1;
        end
        ST_DROP: begin
          tx_data_d = PRIM_SYNC;
          tx_isk_d  = 1'b1;
        end
        default: begin
          tx_data_d = PRIM_SYNC;
          tx_isk_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_75m or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q    <= PRIM_SYNC;
      tx_isk_q     <= 1'b1;
      frame_done_q <= 1'b0;
      err_ovf_q    <= 1'b0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
`ifdef SATA_TX_CRC_ERR_INJ_EN
      inj_q        <= 1'b0;
`endif
    end else begin
      tx_data_q    <= tx_data_d;
      tx_isk_q     <= tx_isk_d;
      frame_done_q <= frame_done_d;
      err_ovf_q    <= err_ovf_d;
      ovf_q        <= ovf_d;
      cnt_q        <= cnt_d;
`ifdef SATA_TX_CRC_ERR_INJ_EN
      inj_q        <= inj_d;
`endif
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_isk       = tx_isk_q;
  assign frame_done   = frame_done_q;
  assign err_oversize = err_ovf_q;

endmodule

// File: tb/tb_sata_tx_framer.sv
// Scoreboard bench for sata_tx_framer: frame-level reference model feeds an
// expected-word queue; a monitor compares every word the framer advances to.
`timescale 1ns/1ps
module tb_sata_tx_framer;

  localparam int unsigned TB_MAX_DW = 5;
  localparam logic [31:0] K_SYNC = 32'hB5B5957C;
  localparam logic [31:0] K_SOF  = 32'h3737B57C;
  localparam logic [31:0] K_EOF  = 32'hD5D5B57C;
  localparam logic [31:0] K_HOLD = 32'hD5D5AA7C;
  localparam logic [31:0] SEED   = 32'h52325032;
  localparam logic [31:0] POLY   = 32'h04C11DB7;

  logic        clk_75m = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        tx_ready = 1'b0;
  logic        s_ready;
  logic [31:0] tx_data;
  logic        tx_isk;
  logic        frame_done;
  logic        err_oversize;
`ifdef SATA_TX_CRC_ERR_INJ_EN
  logic        crc_err_inj = 1'b0;
`endif

  sata_tx_framer #(.MAX_DW(TB_MAX_DW)) dut (
    .clk_75m      (clk_75m),
    .rst_n        (rst_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_isk       (tx_isk),
    .frame_done   (frame_done),
    .err_oversize (err_oversize)
`ifdef SATA_TX_CRC_ERR_INJ_EN
    ,
    .crc_err_inj  (crc_err_inj)
`endif
  );

  always #5 clk_75m = ~clk_75m;

  typedef struct packed {
    logic [31:0] d;
    logic        k;
    logic        fd;
    logic        eo;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          failures = 0;
  int          tx_mode = 0;
  logic [31:0] fdata[16];
  int          fgap[16];

  function automatic void check32(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endfunction

  function automatic void check1(string name, logic act, logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, req);
    end
  endfunction

  // Bit-serial CRC-32, data fed MSB first.
  function automatic logic [31:0] crc_ref(input logic [31:0] crc, input logic [31:0] d);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  function automatic void push_exp(logic [31:0] d, logic k, logic fd, logic eo);
    exp_t e;
    e.d = d; e.k = k; e.fd = fd; e.eo = eo;
    expq.push_back(e);
  endfunction

  // Expected PHY word stream for one frame, SYNC fill excluded.
  function automatic void push_frame(int n, logic inj);
    logic [31:0] crc;
    int          nacc;
    logic        ovf;
    crc  = SEED;
    ovf  = (n > int'(TB_MAX_DW));
    nacc = ovf ? int'(TB_MAX_DW) : n;
    push_exp(K_SOF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < nacc; i++) begin
      push_exp(fdata[i], 1'b0, 1'b0, ovf && (i == nacc - 1));
      crc = crc_ref(crc, fdata[i]);
      if (i < nacc - 1) begin
        for (int g = 0; g < fgap[i]; g++) push_exp(K_HOLD, 1'b1, 1'b0, 1'b0);
      end
    end
    push_exp(crc ^ {31'b0, inj}, 1'b0, 1'b0, 1'b0);
    push_exp(K_EOF, 1'b1, 1'b1, 1'b0);
  endfunction

  initial begin
    forever begin
      @(posedge clk_75m);
      #2;
      case (tx_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // One clock: report handshake/advance at the coming edge, return 2ns after it.
  task automatic tick(output logic acc, output logic adv);
    @(negedge clk_75m);
    acc = s_valid && s_ready;
    adv = tx_ready;
    if (!tx_ready) check1("s_ready_while_stalled", s_ready, 1'b0);
    @(posedge clk_75m);
    #2;
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    expq.delete();
    #1;
    check32("reset_async_tx_data", tx_data, K_SYNC);
    check1("reset_async_frame_done", frame_done, 1'b0);
    @(posedge clk_75m);
    #1;
    check32("reset_edge_tx_data", tx_data, K_SYNC);
    check1("reset_edge_tx_isk", tx_isk, 1'b1);
    @(posedge clk_75m);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input int n, input logic inj, input int rst_after, input int mode);
    logic acc, adv;
    int   budget, g;
    tx_mode = mode;
    push_frame(n, inj);
`ifdef SATA_TX_CRC_ERR_INJ_EN
    crc_err_inj = inj;
`endif
    for (int i = 0; i < n; i++) begin
      s_data  = fdata[i];
      s_last  = (i == n - 1);
      s_valid = 1'b1;
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 400) begin
        tick(acc, adv);
        budget++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!acc) begin
        check1("handshake_timeout", acc, 1'b1);
        return;
      end
      if (rst_after == i + 1) begin
        mid_reset();
        return;
      end
      if (i < n - 1) begin
        g = fgap[i];
        budget = 0;
        while (g > 0 && budget < 400) begin
          tick(acc, adv);
          if (adv) g--;
          budget++;
        end
      end
    end
  endtask

  task automatic clear_gaps();
    for (int i = 0; i < 16; i++) fgap[i] = 0;
  endtask

  // Monitor: every advancing edge either shows SYNC fill or the next expected word.
  initial begin : monitor
    logic        adv, rlow;
    logic [31:0] last_d;
    logic        last_k;
    exp_t        e;
    last_d = K_SYNC;
    last_k = 1'b1;
    forever begin
      @(negedge clk_75m);
      adv  = tx_ready;
      rlow = !rst_n;
      @(posedge clk_75m);
      #1;
      if (rlow || !rst_n) begin
        last_d = K_SYNC;
        last_k = 1'b1;
      end else if (adv) begin
        if (tx_isk && tx_data == K_SYNC) begin
          check1("sync_frame_done", frame_done, 1'b0);
          check1("sync_err_oversize", err_oversize, 1'b0);
          last_d = K_SYNC;
          last_k = 1'b1;
        end else if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%08h/%0b required=none", tx_data, tx_isk);
          last_d = tx_data;
          last_k = tx_isk;
        end else begin
          e = expq.pop_front();
          check32("tx_data", tx_data, e.d);
          check1("tx_isk", tx_isk, e.k);
          check1("frame_done", frame_done, e.fd);
          check1("err_oversize", err_oversize, e.eo);
          last_d = e.d;
          last_k = e.k;
        end
      end else begin
        check32("hold_tx_data", tx_data, last_d);
        check1("hold_tx_isk", tx_isk, last_k);
        check1("stall_frame_done", frame_done, 1'b0);
        check1("stall_err_oversize", err_oversize, 1'b0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stim
    int   n, budget;
    logic inj;
    clear_gaps();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk_75m);
    #1;
    check32("reset_tx_data", tx_data, K_SYNC);
    check1("reset_tx_isk", tx_isk, 1'b1);
    check1("reset_s_ready", s_ready, 1'b0);
    check1("reset_frame_done", frame_done, 1'b0);
    check1("reset_err_oversize", err_oversize, 1'b0);
    #1 rst_n = 1'b1;

    fdata[0] = 32'h00000027;
    run_frame(1, 1'b0, 0, 0);

    for (int i = 0; i < 5; i++) fdata[i] = $urandom;
    fgap[1] = 3;
    run_frame(5, 1'b0, 0, 0);
    clear_gaps();
    run_frame(5, 1'b0, 0, 0);

    for (int i = 0; i < 4; i++) fdata[i] = $urandom;
    run_frame(4, 1'b0, 0, 1);

    for (int i = 0; i < 7; i++) fdata[i] = 32'hA0000000 + i;
    run_frame(7, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) fdata[i] = $urandom;
    run_frame(3, 1'b0, 0, 0);

    for (int i = 0; i < 5; i++) fdata[i] = $urandom;
    run_frame(5, 1'b0, 2, 0);
    for (int i = 0; i < 2; i++) fdata[i] = $urandom;
    run_frame(2, 1'b0, 0, 0);

`ifdef SATA_TX_CRC_ERR_INJ_EN
    for (int i = 0; i < 3; i++) fdata[i] = $urandom;
    run_frame(3, 1'b1, 0, 0);
    run_frame(3, 1'b0, 0, 0);
`endif

    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        fdata[i] = $urandom;
        fgap[i]  = $urandom_range(0, 2);
      end
`ifdef SATA_TX_CRC_ERR_INJ_EN
      inj = 1'($urandom_range(0, 1));
`else
      inj = 1'b0;
`endif
      run_frame(n, inj, 0, $urandom_range(0, 2));
    end
    clear_gaps();

    budget = 0;
    while (expq.size() != 0 && budget < 500) begin
      @(posedge clk_75m);
      budget++;
    end
    repeat (4) @(posedge clk_75m);
    #3;
    check32("queue_drained", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
